mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of every address port.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 rdy  in  1  global enable; low = freeze all internal state.
REQ-005 if_req  in  1  instruction fetch request, level, held until if_done or flushed.
REQ-006 if_addr  in  ADDR_WIDTH  fetch base address, stable while if_req high.
REQ-007 if_flush  in  1  abort any in-flight fetch (branch redirect).
REQ-008 if_done  out  1  one-cycle pulse, if_data valid.
REQ-009 if_data  out  32  fetched word, little-endian.
REQ-010 mem_req  in  1  load/store request, level, held until mem_done.
REQ-011 mem_we  in  1  1 = store, 0 = load.
REQ-012 mem_len  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-013 mem_addr  in  ADDR_WIDTH  load/store base address.
REQ-014 mem_wdata  in  32  store data, byte 0 = bits 7:0.
REQ-015 mem_done  out  1  one-cycle pulse, load data valid or store complete.
REQ-016 mem_rdata  out  32  load data, zero-extended above length.
REQ-017 ram_din  in  8  RAM read byte, valid one cycle after address presented.
REQ-018 ram_a  out  ADDR_WIDTH  RAM byte address.
REQ-019 ram_dout  out  8  RAM write byte.
REQ-020 ram_wr  out  1  1 = write ram_dout to ram_a this cycle.

Function
REQ-021 FSM states SHALL be IDLE, IF_RD, MEM_RD, MEM_WR, DONE; byte counter cnt 0..4; N = 1/2/4 from mem_len, N = 4 for fetch.
REQ-022 Requests SHALL be sampled only in IDLE; mem_req wins over if_req when both high.
REQ-023 Accept: latch base address, N, write data; cnt = 0; go to IF_RD, MEM_RD or MEM_WR.
REQ-024 Read states: while cnt < N drive ram_a = base+cnt, ram_wr = 0; when cnt >= 1 capture ram_din into byte cnt-1; cnt increments each cycle; at cnt = N capture final byte, go to DONE.
REQ-025 Write states: drive ram_a = base+cnt, ram_dout = byte cnt, ram_wr = 1; at cnt = N-1 go to DONE; exactly N write cycles.
REQ-026 DONE SHALL last one cycle, assert if_done or mem_done matching the finished operation, ignore all requests, then return to IDLE.
REQ-027 Latency from accepting edge to done pulse: read N+2 cycles, write N+1 cycles.
REQ-028 if_data/mem_rdata SHALL hold last completed value until next completion of same port; unused upper bytes of mem_rdata = 0.
REQ-029 if_flush high in IF_RD SHALL return to IDLE next edge with no if_done; if_flush high in IDLE SHALL block acceptance of if_req that cycle; if_flush has no effect on MEM_RD/MEM_WR/DONE of a memory op.
REQ-030 rdy low: state, cnt, captured data frozen; ram_wr forced 0; done outputs forced 0; resume exactly where paused, repeating the pending address.
REQ-031 Outside MEM_WR, ram_wr = 0; in IDLE and DONE, ram_a = 0, ram_dout = 0.
REQ-032 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-033 rst high SHALL immediately force IDLE, cnt = 0, all outputs 0, if_data = mem_rdata = 0.
REQ-034 Reset mid-write SHALL abort with ram_wr low immediately; bytes already written stay written; no done pulse.

Verification
REQ-035 Fetch 0x100, RAM bytes 13 00 00 93 -> ram_a 100..103 on consecutive cycles, if_done 6 cycles after accept, if_data = 0x93000013.
REQ-036 Store word 0xDEADBEEF at 0x200 -> ram_wr 4 cycles, ram_a 200..203, ram_dout EF BE AD DE, mem_done 5 cycles after accept.
REQ-037 Load half at 0x300, bytes 34 12 -> mem_rdata = 0x00001234, mem_done 4 cycles after accept.
REQ-038 if_req and mem_req same IDLE cycle -> memory op first, DONE gap, fetch accepted next IDLE cycle, both complete.
REQ-039 if_flush asserted in second IF_RD cycle -> IDLE next edge, no if_done, new if_req accepted the following cycle.
REQ-040 rdy low two cycles mid store, then rst mid store -> no writes while paused, ram_wr and all outputs 0 immediately on rst, no mem_done.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Request, response and byte-RAM bus of the shared-memory controller.
// slave = controller side, master = requesters plus RAM.
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic                  if_done;
    logic [31:0]           if_data;

    logic                  mem_req;
    logic                  mem_we;
    logic [1:0]            mem_len;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_done;
    logic [31:0]           mem_rdata;

    logic [7:0]            ram_din;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic [7:0]            ram_dout;
    logic                  ram_wr;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_done, if_data,
        input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        output mem_done, mem_rdata,
        input  ram_din,
        output ram_a, ram_dout, ram_wr
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_done, if_data,
        output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        input  mem_done, mem_rdata,
        output ram_din,
        input  ram_a, ram_dout, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetches and load/stores
// onto a single 8-bit RAM with one cycle of read latency.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    mem_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  fetch_q, fetch_d;
    logic [31:0]           buf_q, buf_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;
    logic [1:0]            byte_idx;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        fetch_d     = fetch_q;
        buf_d       = buf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        byte_idx    = cnt_q[1:0] - 2'd1;

        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    base_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    fetch_d = 1'b0;
                    cnt_d   = 3'd0;
                    buf_d   = 32'd0;
                    case (bus.mem_len)
                        2'b00:   len_d = 3'd1;
                        2'b01:   len_d = 3'd2;
                        default: len_d = 3'd4;
                    endcase
                    state_d = bus.mem_we ? MEM_WR : MEM_RD;
                end else if (bus.if_req && !bus.if_flush) begin
                    base_d  = bus.if_addr;
                    fetch_d = 1'b1;
                    len_d   = 3'd4;
                    cnt_d   = 3'd0;
                    buf_d   = 32'd0;
                    state_d = IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                if (state_q == IF_RD && bus.if_flush) begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end else begin
                    // ram_din carries the byte addressed in the previous cycle.
                    if (cnt_q != 3'd0) buf_d[{byte_idx, 3'b000} +: 8] = bus.ram_din;
                    if (cnt_q == len_q) begin
                        cnt_d   = 3'd0;
                        state_d = DONE;
                        if (fetch_q) if_data_d   = buf_d;
                        else         mem_rdata_d = buf_d;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            MEM_WR: begin
                if (cnt_q == len_q - 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            base_q      <= '0;
            wdata_q     <= 32'd0;
            fetch_q     <= 1'b0;
            buf_q       <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            fetch_q     <= fetch_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // RAM port is decoded from registered state; a paused cycle keeps presenting
    // the pending address while suppressing the write strobe.
    always_comb begin
        bus.ram_a    = '0;
        bus.ram_dout = 8'd0;
        bus.ram_wr   = 1'b0;
        case (state_q)
            IF_RD, MEM_RD: begin
                if (cnt_q < len_q) bus.ram_a = base_q + ADDR_WIDTH'(cnt_q);
            end
            MEM_WR: begin
                bus.ram_a    = base_q + ADDR_WIDTH'(cnt_q);
                bus.ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                bus.ram_wr   = rdy;
            end
            default: ;
        endcase
    end

    assign bus.if_done   = (state_q == DONE) &&  fetch_q && rdy;
    assign bus.mem_done  = (state_q == DONE) && !fetch_q && rdy;
    assign bus.if_data   = if_data_q;
    assign bus.mem_rdata = mem_rdata_q;

endmodule
